// File: rtl/voice_mixer.sv
// ---------------------------------------------------------------------------
// voice_mixer
//
// Mixes NUM_VOICES unsigned voice samples into one output sample. A strobe
// in IDLE captures the voice bus and mode. The captured voices are then
// summed one per cycle, while the non-zero voices are counted. In mode 0 the
// output is the sum, clamped to the output range. In mode 1 the output is
// the average over the non-zero voices. That average is computed by a
// bit-serial restoring divider.
//
// Ports
//   clk            single clock, all state changes on the rising edge
//   rst            synchronous, active-high reset
//   voices         flattened voice bus, voice i at [i*IN_W +: IN_W]
//   mode           0 = saturating sum, 1 = average over non-zero voices
//   sample_strobe  request to start a mix; accepted only while idle
//   mixed_sample   registered mix result, held until the next result
//   sample_valid   one-cycle pulse when mixed_sample is updated
//   active_count   number of non-zero voices in the last completed mix
//   busy           high whenever a mix is in progress (any state but IDLE)
//   overrun        one-cycle pulse the cycle after a strobe arrives while busy
// ---------------------------------------------------------------------------
module voice_mixer #(
   parameter int NUM_VOICES = 13,
   parameter int IN_W       = 8,
   parameter int OUT_W      = 12
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_VOICES*IN_W-1:0]        voices,
   input  logic                              mode,
   input  logic                              sample_strobe,
   output logic [OUT_W-1:0]                  mixed_sample,
   output logic                              sample_valid,
   output logic [$clog2(NUM_VOICES+1)-1:0]   active_count,
   output logic                              busy,
   output logic                              overrun
);

   localparam int SUM_W  = IN_W + $clog2(NUM_VOICES);
   localparam int CNT_W  = $clog2(NUM_VOICES + 1);
   localparam int BUS_W  = NUM_VOICES * IN_W;
   localparam int IDX_MAX = (NUM_VOICES > SUM_W) ? NUM_VOICES : SUM_W;
   localparam int IDX_W  = $clog2(IDX_MAX);
   localparam int WIDE_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DIVIDE,
      DONE
   } state_t;

   state_t             state_q;
   logic [BUS_W-1:0]   capVoices_q;
   logic               capMode_q;
   logic [SUM_W-1:0]   sum_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   rem_q;
   logic [IDX_W-1:0]   index_q;
   logic [OUT_W-1:0]   mixed_q;
   logic               valid_q;
   logic [CNT_W-1:0]   activeCount_q;
   logic               overrun_q;

   logic [IN_W-1:0]    curVoice;
   logic               voiceNonZero;
   logic [SUM_W-1:0]   sumPlus_d;
   logic [CNT_W-1:0]   countPlus_d;
   logic [CNT_W:0]     remShift_d;
   logic               remFits;
   logic [CNT_W-1:0]   remSub_d;
   logic [WIDE_W-1:0]  sumWide;
   logic [WIDE_W-1:0]  satMax;
   logic [OUT_W-1:0]   result_d;

   // Accumulation datapath. The captured bus is shifted right by one voice
   // every ACCUM cycle, so the voice being added is always the low slice.
   // This avoids a wide variable-index multiplexer.
   always_comb begin
      curVoice     = capVoices_q[IN_W-1:0];
      voiceNonZero = |curVoice;
      sumPlus_d    = sum_q + SUM_W'(curVoice);
      countPlus_d  = count_q + CNT_W'(voiceNonZero);
   end

   // One restoring-division step. The sum register doubles as the dividend
   // and quotient shift register. The dividend MSB shifts into the partial
   // remainder, and the new quotient bit shifts in at the bottom. The
   // remainder is always below the divisor, so CNT_W bits hold it. The
   // shifted value needs one extra bit. The subtraction is only used when
   // its result is below the divisor, so the low CNT_W bits are exact.
   always_comb begin
      remShift_d = {rem_q, sum_q[SUM_W-1]};
      remFits    = (remShift_d >= {1'b0, count_q});
      remSub_d   = remShift_d[CNT_W-1:0] - count_q;
   end

   // Output formatting. In mode 0, sum_q holds the raw sum, which may need
   // clamping. In mode 1 with two or more active voices, sum_q holds the
   // quotient after the divide. With one active voice it holds that voice.
   // With no active voices it holds zero. All mode-1 cases already fit in
   // OUT_W, so the same clamp serves both modes unchanged.
   always_comb begin
      sumWide  = WIDE_W'(sum_q);
      satMax   = WIDE_W'({OUT_W{1'b1}});
      result_d = sumWide[OUT_W-1:0];
      if (sumWide > satMax) begin
         result_d = {OUT_W{1'b1}};
      end
   end

   // Control FSM and all state registers. sample_valid and overrun are
   // cleared every cycle and set only for the cycle of their event, so
   // neither can stretch beyond a single-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         capVoices_q   <= '0;
         capMode_q     <= 1'b0;
         sum_q         <= '0;
         count_q       <= '0;
         rem_q         <= '0;
         index_q       <= '0;
         mixed_q       <= '0;
         valid_q       <= 1'b0;
         activeCount_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         overrun_q <= sample_strobe && (state_q != IDLE);

         case (state_q)
            IDLE: begin
               if (sample_strobe) begin
                  capVoices_q <= voices;
                  capMode_q   <= mode;
                  sum_q       <= '0;
                  count_q     <= '0;
                  rem_q       <= '0;
                  index_q     <= '0;
                  state_q     <= ACCUM;
               end
            end

            ACCUM: begin
               sum_q       <= sumPlus_d;
               count_q     <= countPlus_d;
               capVoices_q <= capVoices_q >> IN_W;
               if (index_q == IDX_W'(NUM_VOICES - 1)) begin
                  index_q <= '0;
                  rem_q   <= '0;
                  // Averages of zero or one voice need no division.
                  if (capMode_q && (countPlus_d >= CNT_W'(2))) begin
                     state_q <= DIVIDE;
                  end else begin
                     state_q <= DONE;
                  end
               end else begin
                  index_q <= index_q + IDX_W'(1);
               end
            end

            DIVIDE: begin
               if (remFits) begin
                  rem_q <= remSub_d;
                  sum_q <= {sum_q[SUM_W-2:0], 1'b1};
               end else begin
                  rem_q <= remShift_d[CNT_W-1:0];
                  sum_q <= {sum_q[SUM_W-2:0], 1'b0};
               end
               if (index_q == IDX_W'(SUM_W - 1)) begin
                  index_q <= '0;
                  state_q <= DONE;
               end else begin
                  index_q <= index_q + IDX_W'(1);
               end
            end

            DONE: begin
               mixed_q       <= result_d;
               activeCount_q <= count_q;
               valid_q       <= 1'b1;
               state_q       <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mixed_sample = mixed_q;
   assign sample_valid = valid_q;
   assign active_count = activeCount_q;
   assign overrun      = overrun_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_voice_mixer.sv
// ---------------------------------------------------------------------------
// tb_voice_mixer
//
// Self-checking bench for voice_mixer. The main instance uses the default
// parameters. It is tracked every cycle by a timing/arithmetic model. The
// model computes each mix with plain integer sums and division, and predicts
// when the result appears from the latency formula. A second instance, with
// 16 voices and a 10-bit output, exercises output saturation. Directed
// scenarios add literal expectations for latency and results.
// ---------------------------------------------------------------------------
module tb_voice_mixer;

   localparam int NV    = 13;
   localparam int IW    = 8;
   localparam int OW    = 12;
   localparam int CW    = 4;
   localparam int SW    = 12;
   localparam int NV2   = 16;
   localparam int OW2   = 10;
   localparam int CW2   = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NV*IW-1:0]     voices;
   logic                 mode;
   logic                 sampleStrobe;
   logic [OW-1:0]        mixedSample;
   logic                 sampleValid;
   logic [CW-1:0]        activeCount;
   logic                 busy;
   logic                 overrun;

   logic [NV2*IW-1:0]    voices2;
   logic                 mode2;
   logic                 sampleStrobe2;
   logic [OW2-1:0]       mixedSample2;
   logic                 sampleValid2;
   logic [CW2-1:0]       activeCount2;
   logic                 busy2;
   logic                 overrun2;

   int compared   = 0;
   int mismatched = 0;
   logic checkOn  = 1'b0;

   always #5 clk = ~clk;

   voice_mixer #(.NUM_VOICES(NV), .IN_W(IW), .OUT_W(OW)) dut (
      .clk           (clk),
      .rst           (rst),
      .voices        (voices),
      .mode          (mode),
      .sample_strobe (sampleStrobe),
      .mixed_sample  (mixedSample),
      .sample_valid  (sampleValid),
      .active_count  (activeCount),
      .busy          (busy),
      .overrun       (overrun)
   );

   voice_mixer #(.NUM_VOICES(NV2), .IN_W(IW), .OUT_W(OW2)) dutSat (
      .clk           (clk),
      .rst           (rst),
      .voices        (voices2),
      .mode          (mode2),
      .sample_strobe (sampleStrobe2),
      .mixed_sample  (mixedSample2),
      .sample_valid  (sampleValid2),
      .active_count  (activeCount2),
      .busy          (busy2),
      .overrun       (overrun2)
   );

   // Single comparison point: every check in the bench goes through here.
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference arithmetic for one mix: plain integer sum, count, clamp, divide.
   function automatic void mixModel(input logic [NV*IW-1:0] bus, input logic m,
                                    output int res, output int cnt, output int lat);
      int sum;
      sum = 0;
      cnt = 0;
      for (int i = 0; i < NV; i++) begin
         int v;
         v = int'(bus[i*IW +: IW]);
         sum += v;
         if (v != 0) cnt++;
      end
      if (!m) res = (sum > (1 << OW) - 1) ? (1 << OW) - 1 : sum;
      else if (cnt == 0) res = 0;
      else res = sum / cnt;
      lat = (m && cnt >= 2) ? NV + 1 + SW : NV + 1;
   endfunction

   function automatic logic [NV*IW-1:0] allVoices(input int val);
      logic [NV*IW-1:0] b;
      for (int i = 0; i < NV; i++) b[i*IW +: IW] = IW'(val);
      return b;
   endfunction

   // Model state: a countdown to the next result, which is all the
   // externally visible behaviour depends on.
   int   remaining  = 0;
   int   pendMixed  = 0;
   int   pendCount  = 0;
   int   pendLat    = 0;
   int   expMixed   = 0;
   int   expCount   = 0;
   logic expValid   = 1'b0;
   logic expOverrun = 1'b0;
   logic expBusy    = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            remaining  = 0;
            expMixed   = 0;
            expCount   = 0;
            expValid   = 1'b0;
            expOverrun = 1'b0;
         end else begin
            expValid   = 1'b0;
            expOverrun = 1'b0;
            if (remaining > 0) begin
               if (sampleStrobe) expOverrun = 1'b1;
               remaining--;
               if (remaining == 0) begin
                  expValid = 1'b1;
                  expMixed = pendMixed;
                  expCount = pendCount;
               end
            end else if (sampleStrobe) begin
               mixModel(voices, mode, pendMixed, pendCount, pendLat);
               remaining = pendLat;
            end
         end
         expBusy = (remaining > 0);
      end
   end

   // Per-cycle comparison of the main instance against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (checkOn) begin
            checkOutput("cyc sample_valid", sampleValid, expValid);
            checkOutput("cyc overrun", overrun, expOverrun);
            checkOutput("cyc busy", busy, expBusy);
            checkOutput("cyc mixed_sample", mixedSample, expMixed);
            checkOutput("cyc active_count", activeCount, expCount);
         end
      end
   end

   // Strobe one mix into the main instance and wait, bounded, for its
   // result, checking latency and result against literal expectations.
   task automatic applyStimulus(input logic [NV*IW-1:0] v, input logic m,
                                input int wantMixed, input int wantCount,
                                input int wantLat, input string name);
      int n;
      int got;
      voices       = v;
      mode         = m;
      sampleStrobe = 1'b1;
      @(posedge clk);
      #1;
      sampleStrobe = 1'b0;
      n   = 0;
      got = 0;
      while (n < 100 && got == 0) begin
         @(posedge clk);
         #1;
         n++;
         if (sampleValid) got = 1;
      end
      checkOutput({name, " latency"}, (got != 0) ? n : -1, wantLat);
      checkOutput({name, " mixed_sample"}, mixedSample, wantMixed);
      checkOutput({name, " active_count"}, activeCount, wantCount);
   endtask

   initial begin
      logic [NV*IW-1:0] bus;
      int n;
      int ovPulses;
      int ovCycle;
      int validPulses;
      int validCycle;
      int got;

      rst           = 1'b1;
      mode          = 1'b0;
      sampleStrobe  = 1'b1;
      voices2       = '0;
      mode2         = 1'b0;
      sampleStrobe2 = 1'b0;
      for (int i = 0; i < NV; i++) voices[i*IW +: IW] = IW'($urandom_range(0, 255));

      // Reset held for two edges with random voices and a live strobe.
      @(posedge clk);
      #1;
      checkOn = 1'b1;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      sampleStrobe = 1'b0;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset mixed_sample", mixedSample, 0);
      checkOutput("reset active_count", activeCount, 0);
      checkOutput("reset sample_valid", sampleValid, 0);
      checkOutput("reset overrun", overrun, 0);
      @(posedge clk);
      #1;
      checkOutput("reset strobe dropped", busy, 0);

      // Sum mode: 13 x 10 = 130.
      applyStimulus(allVoices(10), 1'b0, 130, 13, 14, "sum10");

      // Average mode: (100+50+30)/3 = 60, divide path.
      bus = '0;
      bus[0*IW +: IW] = 8'd100;
      bus[1*IW +: IW] = 8'd50;
      bus[2*IW +: IW] = 8'd30;
      applyStimulus(bus, 1'b1, 60, 3, 26, "avg3");

      // Average with no active voices, and with exactly one.
      applyStimulus('0, 1'b1, 0, 0, 14, "avg0");
      bus = '0;
      bus[5*IW +: IW] = 8'd200;
      applyStimulus(bus, 1'b1, 200, 1, 14, "avg1");

      // Average with a remainder: (7+8)/2 = 7.
      bus = '0;
      bus[3*IW +: IW] = 8'd7;
      bus[12*IW +: IW] = 8'd8;
      applyStimulus(bus, 1'b1, 7, 2, 26, "avg2floor");

      // Largest sum still in range: 13 x 255 = 3315; full-scale average 255.
      applyStimulus(allVoices(255), 1'b0, 3315, 13, 14, "sum255");
      applyStimulus(allVoices(255), 1'b1, 255, 13, 26, "avg255");

      // Saturation on the 16-voice, 10-bit instance: 16 x 255 clamps to 1023.
      for (int i = 0; i < NV2; i++) voices2[i*IW +: IW] = 8'd255;
      sampleStrobe2 = 1'b1;
      @(posedge clk);
      #1;
      sampleStrobe2 = 1'b0;
      n   = 0;
      got = 0;
      while (n < 100 && got == 0) begin
         @(posedge clk);
         #1;
         n++;
         if (sampleValid2) got = 1;
      end
      checkOutput("sat latency", (got != 0) ? n : -1, NV2 + 1);
      checkOutput("sat mixed_sample", mixedSample2, 1023);
      checkOutput("sat active_count", activeCount2, 16);

      // Overrun: a second strobe 5 edges into a mix is ignored and flagged
      // in the cycle after it. Inputs changed after capture do not alter
      // the mix, so the result stays 13 x 1 = 13.
      voices       = allVoices(1);
      mode         = 1'b0;
      sampleStrobe = 1'b1;
      @(posedge clk);
      #1;
      sampleStrobe = 1'b0;
      voices       = allVoices(9);
      mode         = 1'b1;
      ovPulses     = 0;
      ovCycle      = -1;
      validPulses  = 0;
      validCycle   = -1;
      for (int k = 1; k <= 30; k++) begin
         if (k == 5) sampleStrobe = 1'b1;
         @(posedge clk);
         #1;
         sampleStrobe = 1'b0;
         if (overrun) begin ovPulses++; ovCycle = k; end
         if (sampleValid) begin validPulses++; validCycle = k; end
      end
      checkOutput("overrun pulses", ovPulses, 1);
      checkOutput("overrun cycle", ovCycle, 5);
      checkOutput("overrun valid pulses", validPulses, 1);
      checkOutput("overrun valid cycle", validCycle, 14);
      checkOutput("overrun mixed_sample", mixedSample, 13);

      // Abort: reset mid-divide (edge 19 of 26), with a strobe in the same
      // cycle. No result may appear, and outputs must clear.
      bus = '0;
      bus[0*IW +: IW] = 8'd100;
      bus[1*IW +: IW] = 8'd50;
      bus[2*IW +: IW] = 8'd30;
      voices       = bus;
      mode         = 1'b1;
      sampleStrobe = 1'b1;
      @(posedge clk);
      #1;
      sampleStrobe = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abort busy before rst", busy, 1);
      rst          = 1'b1;
      sampleStrobe = 1'b1;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      sampleStrobe = 1'b0;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort mixed_sample", mixedSample, 0);
      checkOutput("abort active_count", activeCount, 0);
      validPulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (sampleValid) validPulses++;
      end
      checkOutput("abort no valid", validPulses, 0);
      applyStimulus(allVoices(10), 1'b0, 130, 13, 14, "after abort");

      // Back-to-back: a strobe in the very next idle cycle is accepted.
      applyStimulus(allVoices(2), 1'b0, 26, 13, 14, "b2b first");
      applyStimulus(allVoices(3), 1'b0, 39, 13, 14, "b2b second");

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
